// File: rtl/tilt_control_decoder_if.sv
// Sample bus from the SPI accelerometer controller: one strobe plus a signed X/Y pair.
interface tilt_control_decoder_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         data_update;
    logic signed [DATA_WIDTH-1:0] data_x;
    logic signed [DATA_WIDTH-1:0] data_y;

    modport master (output data_update, output data_x, output data_y);
    modport slave  (input  data_update, input  data_x, input  data_y);
endinterface

// File: rtl/tilt_control_decoder.sv
// Turns calibrated accelerometer samples into debounced left/right levels and a
// fixed-width, re-arming jump pulse. All outputs are registered.
module tilt_control_decoder #(
    parameter int DATA_WIDTH = 16,
    parameter int LR_ON      = 100,
    parameter int LR_OFF     = 60,
    parameter int JUMP_ON    = 200,
    parameter int JUMP_OFF   = 120,
    parameter int DEBOUNCE   = 2,
    parameter int JUMP_PULSE = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   cal,
    tilt_control_decoder_if.slave  smp,
    output logic                   left,
    output logic                   right,
    output logic                   jump,
    output logic                   calibrated
);

    localparam int XW = DATA_WIDTH + 1;
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(JUMP_PULSE + 1);

    localparam logic signed [XW-1:0] LR_ON_T    = XW'(LR_ON);
    localparam logic signed [XW-1:0] LR_OFF_T   = XW'(LR_OFF);
    localparam logic signed [XW-1:0] JUMP_ON_T  = XW'(JUMP_ON);
    localparam logic signed [XW-1:0] JUMP_OFF_T = XW'(JUMP_OFF);

    typedef enum logic [1:0] {LR_CENTER, LR_LEFT, LR_RIGHT} lr_state_t;
    typedef enum logic [1:0] {J_IDLE, J_PULSE, J_REARM} jump_state_t;

    function automatic logic signed [XW-1:0] widen(input logic signed [DATA_WIDTH-1:0] v);
        return {v[DATA_WIDTH-1], v};
    endfunction

    logic signed [DATA_WIDTH-1:0] off_x;
    logic signed [DATA_WIDTH-1:0] off_y;
    lr_state_t                    lr_state;
    jump_state_t                  jump_state;
    logic [DW-1:0]                dcnt;
    logic                         dcnt_left;
    logic [PW-1:0]                pcnt;

    logic signed [XW-1:0] cx;
    logic signed [XW-1:0] cy;
    logic                 qual_l;
    logic                 qual_r;
    logic                 rel_l;
    logic                 rel_r;
    logic                 fire;
    logic                 rearm;
    logic [DW-1:0]        run_cnt;

    // One extra bit keeps the offset subtraction exact over the full input range.
    assign cx     = widen(smp.data_x) - widen(off_x);
    assign cy     = widen(smp.data_y) - widen(off_y);
    assign qual_l = cx > LR_ON_T;
    assign qual_r = cx < -LR_ON_T;
    assign rel_l  = cx <= LR_OFF_T;
    assign rel_r  = cx >= -LR_OFF_T;
    assign fire   = cy > JUMP_ON_T;
    assign rearm  = cy < JUMP_OFF_T;

    // A run continues only if it points the same way as the one being counted.
    always_comb begin
        run_cnt = DW'(1);
        if (dcnt != '0 && ((qual_l && dcnt_left) || (qual_r && !dcnt_left)))
            run_cnt = dcnt + DW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            off_x      <= '0;
            off_y      <= '0;
            calibrated <= 1'b0;
            lr_state   <= LR_CENTER;
            jump_state <= J_IDLE;
            dcnt       <= '0;
            dcnt_left  <= 1'b0;
            pcnt       <= '0;
            left       <= 1'b0;
            right      <= 1'b0;
            jump       <= 1'b0;
        end else if (cal) begin
            off_x      <= smp.data_x;
            off_y      <= smp.data_y;
            calibrated <= 1'b1;
            lr_state   <= LR_CENTER;
            jump_state <= J_IDLE;
            dcnt       <= '0;
            pcnt       <= '0;
            left       <= 1'b0;
            right      <= 1'b0;
            jump       <= 1'b0;
        end else if (!enable) begin
            lr_state   <= LR_CENTER;
            jump_state <= J_IDLE;
            dcnt       <= '0;
            pcnt       <= '0;
            left       <= 1'b0;
            right      <= 1'b0;
            jump       <= 1'b0;
        end else begin
            if (smp.data_update) begin
                case (lr_state)
                    LR_CENTER: begin
                        if (qual_l || qual_r) begin
                            if (run_cnt == DW'(DEBOUNCE)) begin
                                lr_state <= qual_l ? LR_LEFT : LR_RIGHT;
                                left     <= qual_l;
                                right    <= qual_r;
                                dcnt     <= '0;
                            end else begin
                                dcnt      <= run_cnt;
                                dcnt_left <= qual_l;
                            end
                        end else begin
                            dcnt <= '0;
                        end
                    end
                    LR_LEFT: begin
                        if (rel_l) begin
                            lr_state <= LR_CENTER;
                            left     <= 1'b0;
                        end
                    end
                    LR_RIGHT: begin
                        if (rel_r) begin
                            lr_state <= LR_CENTER;
                            right    <= 1'b0;
                        end
                    end
                    default: begin
                        lr_state <= LR_CENTER;
                        left     <= 1'b0;
                        right    <= 1'b0;
                    end
                endcase
            end

            // The pulse counter runs on every clock, independent of sample strobes.
            case (jump_state)
                J_IDLE: begin
                    if (smp.data_update && fire) begin
                        jump_state <= J_PULSE;
                        pcnt       <= PW'(JUMP_PULSE);
                        jump       <= 1'b1;
                    end
                end
                J_PULSE: begin
                    if (pcnt == PW'(1)) begin
                        jump_state <= J_REARM;
                        pcnt       <= '0;
                        jump       <= 1'b0;
                    end else begin
                        pcnt <= pcnt - PW'(1);
                    end
                end
                J_REARM: begin
                    if (smp.data_update && rearm)
                        jump_state <= J_IDLE;
                end
                default: begin
                    jump_state <= J_IDLE;
                    pcnt       <= '0;
                    jump       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tilt_control_decoder.sv
// Randomized and directed bench for tilt_control_decoder against a behavioural model.
module tb_tilt_control_decoder;

    localparam int W    = 16;
    localparam int LON  = 100;
    localparam int LOFF = 60;
    localparam int JON  = 200;
    localparam int JOFF = 120;
    localparam int DEB  = 2;
    localparam int P    = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b1;
    logic cal = 1'b0;
    logic left, right, jump, calibrated;

    tilt_control_decoder_if #(.DATA_WIDTH(W)) smp ();

    tilt_control_decoder #(
        .DATA_WIDTH(W), .LR_ON(LON), .LR_OFF(LOFF), .JUMP_ON(JON),
        .JUMP_OFF(JOFF), .DEBOUNCE(DEB), .JUMP_PULSE(P)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .cal(cal), .smp(smp),
        .left(left), .right(right), .jump(jump), .calibrated(calibrated)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: lr is -1/0/+1, run is a signed run length (+ toward left, - toward right),
    // fire_edge is the clock edge that captured the last firing sample.
    int m_off_x, m_off_y, m_lr, m_run, m_fire, m_cal, m_armed, m_edge;

    function automatic void model_clear();
        m_lr    = 0;
        m_run   = 0;
        m_armed = 1;
        m_fire  = -1000;
    endfunction

    function automatic void model_reset();
        model_clear();
        m_off_x = 0;
        m_off_y = 0;
        m_cal   = 0;
    endfunction

    function automatic void model_step(input bit du, input int x, input int y, input bit c, input bit en);
        int cx, cy;
        m_edge++;
        if (c) begin
            m_off_x = x;
            m_off_y = y;
            m_cal   = 1;
            model_clear();
        end else if (!en) begin
            model_clear();
        end else if (du) begin
            cx = x - m_off_x;
            cy = y - m_off_y;
            if (m_lr == 0) begin
                if (cx > LON) begin
                    m_run = (m_run > 0) ? m_run + 1 : 1;
                    if (m_run >= DEB) begin m_lr = 1; m_run = 0; end
                end else if (cx < -LON) begin
                    m_run = (m_run < 0) ? m_run - 1 : -1;
                    if (-m_run >= DEB) begin m_lr = -1; m_run = 0; end
                end else begin
                    m_run = 0;
                end
            end else if (m_lr == 1 && cx <= LOFF) begin
                m_lr = 0;
            end else if (m_lr == -1 && cx >= -LOFF) begin
                m_lr = 0;
            end
            if (m_armed == 1 && cy > JON) begin
                m_armed = 0;
                m_fire  = m_edge;
            end else if (m_armed == 0 && m_edge > m_fire + P && cy < JOFF) begin
                m_armed = 1;
            end
        end
    endfunction

    function automatic bit exp_jump();
        return (m_edge >= m_fire) && (m_edge <= m_fire + P - 1);
    endfunction

    task automatic cyc(input bit du, input int x, input int y, input bit c = 1'b0, input bit en = 1'b1);
        smp.data_update = du;
        smp.data_x      = 16'(x);
        smp.data_y      = 16'(y);
        cal             = c;
        enable          = en;
        model_step(du, x, y, c, en);
        @(posedge clk);
        @(negedge clk);
        check("left", left, 32'(m_lr == 1));
        check("right", right, 32'(m_lr == -1));
        check("jump", jump, 32'(exp_jump()));
        check("calibrated", calibrated, 32'(m_cal));
    endtask

    int xs[19] = '{0, 50, -50, 60, -60, 61, -61, 80, -80, 99, -99, 100, -100, 101, -101, 150, -150, 300, -300};
    int ys[10] = '{0, 100, 119, 120, 121, 150, 200, 201, 250, -200};

    initial begin
        int hi;
        smp.data_update = 1'b0;
        smp.data_x      = '0;
        smp.data_y      = '0;
        m_edge = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_left", left, 0);
        check("rst_right", right, 0);
        check("rst_jump", jump, 0);
        check("rst_calibrated", calibrated, 0);
        reset = 1'b1;

        // debounce entry
        cyc(1, 150, 0); check("deb_one_sample", left, 0);
        cyc(1, 150, 0); check("deb_left_rise", left, 1);
        cyc(1, 0, 0);
        cyc(1, 150, 0); cyc(1, 0, 0); cyc(1, 150, 0);
        check("deb_interrupted", left, 0);
        cyc(1, 0, 0);

        // hysteresis
        cyc(1, 150, 0); cyc(1, 150, 0);
        cyc(1, 80, 0);  check("hyst_left_hold", left, 1);
        cyc(1, 60, 0);  check("hyst_left_release", left, 0);
        cyc(1, -150, 0); cyc(1, -150, 0);
        cyc(1, -61, 0); check("hyst_right_hold", right, 1);
        cyc(1, -60, 0); check("hyst_right_release", right, 0);

        // direction swing
        cyc(1, 150, 0); cyc(1, 150, 0);
        cyc(1, -150, 0); check("swing_left_fall", left, 0); check("swing_right_low", right, 0);
        cyc(1, -150, 0); cyc(1, -150, 0); check("swing_right_rise", right, 1);
        cyc(1, 0, 0);

        // jump: held tilt gives one pulse of exactly P cycles
        hi = 0;
        for (int i = 0; i < 5; i++) begin cyc(1, 0, 250); hi += int'(jump); end
        for (int i = 0; i < 12; i++) begin cyc(0, 0, 0); hi += int'(jump); end
        check("pulse_len", hi, P);
        cyc(1, 0, 150); cyc(1, 0, 250); check("no_rearm_150", jump, 0);
        cyc(1, 0, 100); cyc(1, 0, 250); check("rearm_pulse", jump, 1);
        repeat (10) cyc(0, 0, 0);
        cyc(1, 0, 0);

        // calibration
        cyc(0, 500, 300, 1'b1); check("cal_rise", calibrated, 1);
        cyc(1, 560, 300); check("cal_cx60", left, 0);
        cyc(1, 650, 300); cyc(1, 650, 300); check("cal_left", left, 1);
        cyc(1, 500, 300);
        cyc(1, 700, 300); cyc(1, 700, 300, 1'b1); cyc(1, 900, 300);
        check("cal_drops_sample", left, 0);
        cyc(0, -32768, 0, 1'b1);
        cyc(1, 32767, 0); cyc(1, 32767, 0); check("extreme_left", left, 1);

        // enable low in LEFT, offsets survive
        cyc(0, 0, 0, 1'b0, 1'b0); check("enable_low_left", left, 0);
        cyc(1, -32618, 0); cyc(1, -32618, 0); check("offset_retained", left, 1);
        cyc(0, 0, 0, 1'b1);

        // asynchronous reset mid-pulse
        cyc(1, 0, 250); cyc(0, 0, 0); check("pulse_active", jump, 1);
        reset = 1'b0;
        #1;
        check("async_jump", jump, 0);
        check("async_calibrated", calibrated, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 0, 0); check("post_reset_quiet", jump, 0);
        cyc(1, 0, 250); check("post_reset_fire", jump, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 60,
                xs[$urandom_range(0, 18)],
                ys[$urandom_range(0, 9)],
                $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) >= 5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/tilt_control_decoder.md
# tilt_control_decoder

Parametrised decoder that turns signed accelerometer samples from the SPI controller into the game's left, right and jump controls. It replaces fixed-threshold compares with:
- a zero-offset calibration capture;
- hysteresis on every axis;
- entry debounce for left/right;
- a fixed-width, re-arming jump pulse.

It sits between the SPI controller's `data_x`/`data_y`/`data_update` outputs and the game logic. Every output is registered.

## Interface
- DATA_WIDTH, 16, sample width; samples are two's complement.
- LR_ON, 100, corrected |x| above which a tilt starts to count toward left/right.
- LR_OFF, 60, corrected |x| at or below which left/right releases. Must satisfy 0 ≤ LR_OFF < LR_ON.
- JUMP_ON, 200, corrected y above which a jump fires.
- JUMP_OFF, 120, corrected y below which jump re-arms. Must satisfy JUMP_OFF < JUMP_ON.
- DEBOUNCE, 2, consecutive qualifying samples needed to enter LEFT/RIGHT. Must be ≥ 1.
- JUMP_PULSE, 8, clk cycles that `jump` stays high per jump. Must be ≥ 1.

Ports:
- clk  input  1  system clock, the only clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  low forces the idle state, clears the debounce counter and drives all outputs to 0.
- cal  input  1  one-cycle strobe; captures the current data_x/data_y as zero offsets.
- data_update  input  1  one-cycle strobe; data_x/data_y are valid in that cycle.
- data_x  input  DATA_WIDTH  signed X sample.
- data_y  input  DATA_WIDTH  signed Y sample.
- left  output  1  level; high while in LEFT.
- right  output  1  level; high while in RIGHT.
- jump  output  1  pulse, JUMP_PULSE cycles long.
- calibrated  output  1  high once any cal has been taken.

## Operation
- Offsets `off_x` and `off_y` are DATA_WIDTH signed registers, reset to 0.
- Corrected value: `cx = data_x − off_x`, `cy = data_y − off_y`, computed at DATA_WIDTH+1 bits signed. The result never overflows and no saturation is applied.
- Thresholds are sign-extended to DATA_WIDTH+1 bits. Every compare is signed.
- `cal` handling:
  - Loads the offsets.
  - Sets `calibrated`.
  - Forces LR to CENTER and jump to IDLE, clears the debounce counter and deasserts all control outputs.
  - If `cal` and `data_update` arrive in the same cycle, `cal` wins and the sample is discarded.
- The state machines advance only on cycles where `data_update`=1, `enable`=1 and `cal`=0. The one exception is the jump pulse counter, which counts every clk.
- LR state machine (CENTER, LEFT, RIGHT), debounce counter `dcnt`:
  - CENTER, `cx > LR_ON`: increment dcnt; if dcnt reaches DEBOUNCE, go to LEFT and clear dcnt.
  - CENTER, `cx < −LR_ON`: same rule, but go to RIGHT.
  - A non-qualifying sample, or a sample qualifying for the opposite direction, restarts dcnt. The opposite-direction sample counts as 1 toward its own direction, so dcnt tracks the direction of the most recent run.
  - LEFT → CENTER on the first sample with `cx ≤ LR_OFF`.
  - RIGHT → CENTER on the first sample with `cx ≥ −LR_OFF`.
  - LEFT and RIGHT never go directly to each other; a swing passes through CENTER and must re-debounce.
  - Values strictly between LR_OFF and LR_ON hold the current state.
- Jump state machine (IDLE, PULSE, REARM):
  - IDLE, sample with `cy > JUMP_ON`: go to PULSE and load `pcnt` = JUMP_PULSE.
  - PULSE: `jump` = 1; pcnt decrements every clk. When pcnt reaches 1, go to REARM on the next clk.
  - REARM, sample with `cy < JUMP_OFF`: go to IDLE.
  - Holding the board tilted yields exactly one pulse.
  - A re-arming sample that arrives during PULSE is ignored.
- `enable` low takes effect the next clk:
  - LR goes to CENTER and jump to IDLE.
  - Counters clear and outputs go to 0.
  - Offsets and `calibrated` are retained.

## Timing
- Reset values: left=0, right=0, jump=0, calibrated=0, off_x=off_y=0, LR=CENTER, jump FSM=IDLE, dcnt=0, pcnt=0.
- Latency: a `data_update` in cycle N that completes a transition is visible on left/right/jump in cycle N+1.
- A jump pulse is high for exactly JUMP_PULSE consecutive cycles, N+1 through N+JUMP_PULSE.
- `calibrated` rises in the cycle after `cal`.
- Asynchronous reset mid-pulse drops `jump` immediately. After reset, a new pulse needs a fresh sample above JUMP_ON.
- `data_update` strobes may arrive back-to-back (every cycle); each one counts as a sample.

## Test plan
- **Debounce entry.** DEBOUNCE=2, offsets 0. Apply x=150, then x=150 → left rises 1 cycle after the second strobe. Apply x=150, x=0, x=150 → left stays 0.
- **Hysteresis.** From LEFT, x=80 → left holds. x=60 → left falls 1 cycle later. From RIGHT, x=−61 → hold; x=−60 → release.
- **Direction swing.** From LEFT, x=−150 → first strobe goes to CENTER (left falls, right=0). Two further strobes at −150 → right rises.
- **Jump.** y=250 held for 5 samples → exactly one pulse of 8 cycles. y=100 then y=250 → second pulse. y=150 does not re-arm.
- **Calibration.**
  - cal with x=500, y=300 → calibrated=1 next cycle.
  - Sample x=560 → left stays 0 (cx=60).
  - Two samples at x=650 → left=1.
  - cal coinciding with data_update → sample ignored.
  - Extremes: x=32767 with off_x=−32768 → cx=65535 with no wrap, so the sample qualifies for left.
- **Reset/enable mid-operation.**
  - reset low mid-pulse → jump=0 asynchronously.
  - enable low in LEFT → left=0 next cycle; offsets retained after enable returns.
